// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned 32x32 shift-add multiplier that borrows
// the shared 32-bit ALU as its adder. When idle the ALU ports are a plain
// passthrough of the external datapath request.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
  input  logic [31:0] ext_src1_i,
  input  logic [31:0] ext_src2_i,
  input  logic [3:0]  ext_ctrl_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_cout_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  count_q, count_d;

  // State and datapath registers; reset clears everything and aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and ALU steering: the ALU adds hi + (lo[0] ? M : 0)
  // during RUN, and the 33-bit sum shifted right by one folds into {hi,lo}.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    count_d    = count_q;
    alu_src1_o = ext_src1_i;
    alu_src2_o = ext_src2_i;
    alu_ctrl_o = ext_ctrl_i;
    busy_o     = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d     = mcand_i;
          hi_d    = '0;
          lo_d    = mplier_i;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy_o     = 1'b1;
        alu_ctrl_o = ALU_ADD;
        alu_src1_o = hi_q;
        alu_src2_o = lo_q[0] ? m_q : 32'h0;
        hi_d       = {alu_cout_i, alu_result_i[31:1]};
        lo_d       = {alu_result_i[0], lo_q[31:1]};
        count_d    = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = DONE;
        end
      end

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // {hi,lo} is itself registered and frozen outside RUN, so it serves
  // directly as the held product.
  assign product_o = {hi_q, lo_q};

endmodule
